// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: writeback select and funct3 encodings,
// the MEM/WB register bundle, its reset value and the access legality rule.
package pipeline_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic        reg_write;
      logic        misalign;
      logic [4:0]  rd;
      logic [1:0]  result_src;
      logic [2:0]  funct3;
      logic [1:0]  lane;
      logic [31:0] alu_result;
      logic [31:0] pc_plus4;
      logic [31:0] rdata;
   } mem_wb_t;

   localparam mem_wb_t MEM_WB_RST = '0;

   // bu/hu only exist for loads; stores treat them as illegal.
   function automatic logic access_ok(
      input logic [2:0] f3,
      input logic [1:0] lane,
      input logic       is_load
   );
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~lane[0];
         F3_W:    ok = (lane == 2'b00);
         F3_BU:   ok = is_load;
         F3_HU:   ok = is_load & ~lane[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/memory_writeback_stage_if.sv
// M-stage inputs and W-stage register-file write port of the memory stage.
// master: execute side driving M / consuming W; slave: the stage itself.
interface memory_writeback_stage_if;

   logic        RegWriteM;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [4:0]  RdM;
   logic [31:0] PCPlus4M;

   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        MisalignW;

   modport master (
      output RegWriteM, MemWriteM, ResultSrcM, Funct3M,
      output ALUResultM, WriteDataM, RdM, PCPlus4M,
      input  RegWriteW, RdW, ResultW, MisalignW
   );

   modport slave (
      input  RegWriteM, MemWriteM, ResultSrcM, Funct3M,
      input  ALUResultM, WriteDataM, RdM, PCPlus4M,
      output RegWriteW, RdW, ResultW, MisalignW
   );

endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM with per-byte write enables and async read.
// Ports: clk, we, be[3:0], addr (word index), wd write data, rd read data.
module data_memory #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wd,
   output logic [31:0]   rd
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   assign rd = mem[addr];

endmodule

// File: rtl/memory_writeback_stage.sv
// Memory + writeback stage: store steering, legality, MEM/WB register,
// load extension, result mux. Ports: clk, rst (sync, active-low), bus.
module memory_writeback_stage
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   memory_writeback_stage_if.slave  bus
);

   logic [AW-1:0] word_addr;
   logic [1:0]    lane;
   logic          is_load;
   logic          st_ok;
   logic          ld_ok;
   logic          we;
   logic [3:0]    be;
   logic [31:0]   wd;
   logic [31:0]   rdata;
   logic          unused_addr;

   mem_wb_t q;
   mem_wb_t d;

   // Upper address bits are dropped so accesses wrap over the RAM.
   assign word_addr   = bus.ALUResultM[AW+1:2];
   assign lane        = bus.ALUResultM[1:0];
   assign unused_addr = ^bus.ALUResultM[31:AW+2];

   assign is_load = (bus.ResultSrcM == RES_MEM);
   assign st_ok   = access_ok(bus.Funct3M, lane, 1'b0);
   assign ld_ok   = access_ok(bus.Funct3M, lane, 1'b1);

   assign we = rst & bus.MemWriteM & st_ok;

   // Replicate the low byte/half across the word; be picks the lanes.
   always_comb begin
      be = 4'b0000;
      wd = bus.WriteDataM;
      case (bus.Funct3M)
         F3_B: begin
            be = 4'b0001 << lane;
            wd = {4{bus.WriteDataM[7:0]}};
         end
         F3_H: begin
            be = lane[1] ? 4'b1100 : 4'b0011;
            wd = {2{bus.WriteDataM[15:0]}};
         end
         F3_W: begin
            be = 4'b1111;
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

   data_memory #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dmem (
      .clk  (clk),
      .we   (we),
      .be   (be),
      .addr (word_addr),
      .wd   (wd),
      .rd   (rdata)
   );

   always_comb begin
      d            = MEM_WB_RST;
      d.reg_write  = bus.RegWriteM & ~(is_load & ~ld_ok);
      d.misalign   = (bus.MemWriteM & ~st_ok) | (is_load & ~ld_ok);
      d.rd         = bus.RdM;
      d.result_src = bus.ResultSrcM;
      d.funct3     = bus.Funct3M;
      d.lane       = lane;
      d.alu_result = bus.ALUResultM;
      d.pc_plus4   = bus.PCPlus4M;
      d.rdata      = rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) q <= MEM_WB_RST;
      else      q <= d;
   end

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_val;
   logic [31:0] result;

   assign lane_byte = 8'(q.rdata >> {q.lane, 3'b000});
   assign lane_half = q.lane[1] ? q.rdata[31:16] : q.rdata[15:0];

   always_comb begin
      load_val = q.rdata;
      case (q.funct3)
         F3_B:    load_val = {{24{lane_byte[7]}}, lane_byte};
         F3_H:    load_val = {{16{lane_half[15]}}, lane_half};
         F3_BU:   load_val = {24'h0, lane_byte};
         F3_HU:   load_val = {16'h0, lane_half};
         default: load_val = q.rdata;
      endcase
   end

   always_comb begin
      result = q.alu_result;
      case (q.result_src)
         RES_MEM: result = load_val;
         RES_PC4: result = q.pc_plus4;
         default: result = q.alu_result;
      endcase
   end

   assign bus.RegWriteW = q.reg_write;
   assign bus.RdW       = q.rd;
   assign bus.ResultW   = result;
   assign bus.MisalignW = q.misalign;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Scoreboard bench for memory_writeback_stage: a byte-array memory model
// predicts each W-stage output; a monitor compares one entry per cycle.
module tb_memory_writeback_stage;

   localparam int DEPTH = 1024;
   localparam int BYTES = DEPTH * 4;

   typedef struct {
      bit        rw;
      bit [4:0]  rd;
      bit [31:0] res;
      bit        mis;
      bit        chk_res;
      int        idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   memory_writeback_stage_if bus();

   memory_writeback_stage #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t     sb[$];
   bit [7:0] ref_mem [BYTES];
   int       checks = 0;
   int       errors = 0;
   int       n_iss  = 0;

   task automatic cmp(input string nm, input int idx,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s idx=%0d got=%h exp=%h", nm, idx, got, want);
      end
   endtask

   task automatic step(input bit rst_v, input bit rw, input bit mw,
                       input bit [1:0] src, input bit [2:0] f3,
                       input bit [31:0] alu, input bit [31:0] wdat,
                       input bit [4:0] rd, input bit [31:0] pc);
      exp_t      e;
      int        a;
      int        n;
      bit        ok_s;
      bit        ok_l;
      bit        is_ld;
      bit [31:0] v;
      @(negedge clk);
      rst            = rst_v;
      bus.RegWriteM  = rw;
      bus.MemWriteM  = mw;
      bus.ResultSrcM = src;
      bus.Funct3M    = f3;
      bus.ALUResultM = alu;
      bus.WriteDataM = wdat;
      bus.RdM        = rd;
      bus.PCPlus4M   = pc;
      a     = int'(alu & 32'(BYTES - 1));
      n     = 1 << f3[1:0];
      ok_s  = (f3 inside {3'd0, 3'd1, 3'd2}) && (a % n == 0);
      ok_l  = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (a % n == 0);
      is_ld = (src == 2'b01);
      e.idx = n_iss;
      n_iss++;
      if (!rst_v) begin
         e.rw = 0; e.rd = 0; e.res = 0; e.mis = 0; e.chk_res = 1;
      end else begin
         v = 0;
         if (ok_l) begin
            for (int i = 0; i < n; i++) v |= 32'(ref_mem[a+i]) << (8*i);
            if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
         end
         e.mis     = (mw && !ok_s) || (is_ld && !ok_l);
         e.rw      = rw && !(is_ld && !ok_l);
         e.rd      = rd;
         e.chk_res = !(is_ld && !ok_l);
         case (src)
            2'b01:   e.res = v;
            2'b10:   e.res = pc;
            default: e.res = alu;
         endcase
         if (mw && ok_s) begin
            for (int i = 0; i < n; i++) ref_mem[a+i] = wdat[8*i +: 8];
         end
      end
      sb.push_back(e);
   endtask

   task automatic sw(input bit [31:0] ad, input bit [31:0] dt);
      step(1, 0, 1, 2'b00, 3'b010, ad, dt, 5'd0, 32'h0);
   endtask

   task automatic ld(input bit [2:0] f3, input bit [31:0] ad,
                     input bit [4:0] rd);
      step(1, 1, 0, 2'b01, f3, ad, 32'h0, rd, 32'h0);
   endtask

   task automatic nop();
      step(1, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("RegWriteW", e.idx, 32'(bus.RegWriteW), 32'(e.rw));
            cmp("RdW", e.idx, 32'(bus.RdW), 32'(e.rd));
            cmp("MisalignW", e.idx, 32'(bus.MisalignW), 32'(e.mis));
            if (e.chk_res) cmp("ResultW", e.idx, bus.ResultW, e.res);
         end
      end
   end

   initial begin
      bit [2:0]  f3s [8];
      bit [31:0] ad;
      int        k;
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
      bus.RegWriteM  = 0;
      bus.MemWriteM  = 0;
      bus.ResultSrcM = 0;
      bus.Funct3M    = 0;
      bus.ALUResultM = 0;
      bus.WriteDataM = 0;
      bus.RdM        = 0;
      bus.PCPlus4M   = 0;

      step(0, 1, 0, 2'b00, 3'b000, 32'h1234, 0, 5'd3, 0);
      step(0, 1, 0, 2'b10, 3'b000, 32'h0, 0, 5'd4, 32'h44);

      for (int w = 0; w < 64; w++) sw(32'(w * 4), $urandom);

      sw(32'h10, 32'hDEADBEEF);
      ld(3'b010, 32'h10, 5'd5);

      sw(32'h20, 32'h80FF7F01);
      ld(3'b000, 32'h23, 5'd6);
      ld(3'b100, 32'h23, 5'd6);
      ld(3'b001, 32'h22, 5'd6);
      ld(3'b101, 32'h20, 5'd6);

      sw(32'h30, 32'h11223344);
      step(1, 0, 1, 2'b00, 3'b000, 32'h31, 32'h0000_00AA, 5'd0, 0);
      ld(3'b010, 32'h30, 5'd8);

      sw(32'h32, 32'hCAFEF00D);
      nop();
      ld(3'b010, 32'h30, 5'd8);
      ld(3'b001, 32'h33, 5'd9);

      step(0, 0, 1, 2'b00, 3'b010, 32'h40, 32'h5555_5555, 5'd0, 0);
      step(0, 1, 0, 2'b00, 3'b000, 32'h99, 0, 5'd7, 0);
      ld(3'b010, 32'h40, 5'd7);
      step(1, 1, 0, 2'b00, 3'b000, 32'h99, 0, 5'd7, 0);

      sw(32'h1010, 32'hA5A5_1234);
      ld(3'b010, 32'h0010, 5'd10);
      step(1, 1, 0, 2'b10, 3'b000, 32'h77, 0, 5'd1, 32'h104);
      step(1, 1, 0, 2'b11, 3'b000, 32'h77, 0, 5'd1, 32'h104);

      for (int i = 0; i < 400; i++) begin
         ad = 32'($urandom_range(0, 255)) | (32'($urandom_range(0, 7)) << 12);
         k  = $urandom_range(0, 7);
         case ($urandom_range(0, 9))
            0: step(0, 1, 1, 2'b00, f3s[k], ad, $urandom, 5'($urandom), 0);
            1, 2, 3: step(1, 0, 1, 2'b00, f3s[k], ad, $urandom, 5'd0, 0);
            4, 5, 6: step(1, 1, 0, 2'b01, f3s[k], ad, 0, 5'($urandom), 0);
            7: step(1, 1, 0, 2'b10, 0, $urandom, 0, 5'($urandom), $urandom);
            default: step(1, $urandom_range(0, 1), 0, 2'($urandom_range(0, 3) | 0) & 2'b11 ^ 2'b01 ^ 2'b01 == 2'b01 ? 2'b00 : 2'($urandom_range(0, 3)) & 2'b10 | 2'b00, 3'b000, $urandom, 0, 5'($urandom), $urandom);
         endcase
      end
      nop();

      repeat (3) @(posedge clk);
      #2;
      cmp("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_writeback_stage.md
# memory_writeback_stage

Memory and writeback end of the pipelined RV32I core. Takes execute-stage results and performs byte/halfword/word loads and stores against an internal data memory. Holds the MEM/WB pipeline register and drives `RegWriteW`, `RdW` and `ResultW` back into the decode stage's register file write port, closing the register-write loop.

## Interface
Parameters:
- `DEPTH`, default 1024: data memory size in 32-bit words. Must be a power of two.
- `AW`, default `$clog2(DEPTH)`: word-index width.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `RegWriteM`  in  1  instruction in M writes rd.
- `MemWriteM`  in  1  instruction in M is a store.
- `ResultSrcM`  in  2  writeback select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- `Funct3M`  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `ALUResultM`  in  32  effective address / ALU result.
- `WriteDataM`  in  32  store data (rs2, already forwarded).
- `RdM`  in  5  destination register.
- `PCPlus4M`  in  32  link value.
- `RegWriteW`  out  1  register file write enable.
- `RdW`  out  5  register file write address.
- `ResultW`  out  32  register file write data; also the forwarding source.
- `MisalignW`  out  1  one-cycle flag: the instruction now in W made an illegal or misaligned access.

## Operation
- The word index is `ALUResultM[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- Byte lane is `ALUResultM[1:0]`.
- **Store legality** (`MemWriteM`=1):
  - sb: always legal.
  - sh: legal when addr[0]=0.
  - sw: legal when addr[1:0]=00.
  - Any other funct3 is illegal.
- **Legal store:** writes only the addressed lanes using byte enables. Data comes from the low byte/half of `WriteDataM`, replicated to the target lane.
- **Illegal store:** memory is not modified, and `MisalignW`=1 the next cycle.
- **Loads** (`ResultSrcM`=01):
  - The legality rules are the same as for stores, with bu/hu treated as b/h.
  - Word data is read combinationally in M. The raw word, the lane, and funct3 are captured in MEM/WB.
  - Lane extraction and sign/zero extension happen in W.
- **Illegal load:** `RegWriteW` is forced to 0 and `MisalignW`=1.
- **Writeback mux in W:**
  - 00 or 11: registered ALU result.
  - 01: extended load data.
  - 10: registered PC+4.
- `RdW` is passed through unmodified. A write to x0 is left to the register file to ignore.
- **Reset** (`rst`=0 at an edge):
  - All MEM/WB fields are cleared, so `RegWriteW`=0, `RdW`=0, `ResultW`=0 and `MisalignW`=0.
  - Stores are suppressed during reset.
  - Memory contents are not cleared.

## Timing
- **Store:** commits at the rising edge that ends the M cycle.
- **Load:** `ResultW` is valid one cycle after the load is in M. The register file captures it at the following edge.
- **ALU / PC+4 results:** same one-cycle latency as loads.
- **Read-during-write:** a load in M sees memory state from before that edge. Back-to-back store then load to the same word returns the new data, because the store committed one edge earlier.
- **Reset mid-stream:** an in-flight M instruction is dropped with no store and no writeback. The first instruction after release behaves normally.
- Outputs are purely registered, except `ResultW`, which is a mux of registered fields with no combinational path from M inputs.

## Structure
- **Shared package `pipeline_pkg`:**
  - ResultSrc encodings (`RES_ALU`, `RES_MEM`, `RES_PC4`).
  - funct3 load/store codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Pipeline register reset constant.
- **Sub-module `data_memory`:**
  - Parameter `DEPTH`.
  - Ports: `clk`, `we`, `be[3:0]`, `addr[AW-1:0]`, `wd[31:0]`, and an asynchronous `rd[31:0]`.
  - Byte-enable write on the rising edge.
- The top level holds store lane steering, legality checks, the MEM/WB register, load extension, and the result mux.

## Test plan
- **Word store then load:**
  - Stimulus: sw 0xDEADBEEF to addr 0x10, next cycle lw 0x10 with rd=5.
  - Required: `ResultW`=0xDEADBEEF, `RdW`=5, `RegWriteW`=1 one cycle after the lw is in M.
- **Sub-word loads:** with word 0x80FF7F01 at 0x20, check each load:
  - lb 0x23 → 0xFFFFFF80
  - lbu 0x23 → 0x00000080
  - lh 0x22 → 0xFFFF80FF
  - lhu 0x20 → 0x00007F01
- **Byte-enable store:**
  - Stimulus: word 0x11223344 at 0x30, then sb 0xAA to 0x31, then lw 0x30.
  - Required: 0x1122AA44.
- **Misaligned accesses:**
  - sw to 0x32: memory unchanged, `MisalignW`=1 for exactly one cycle.
  - lh from 0x33: `RegWriteW`=0, `MisalignW`=1.
- **Reset mid-stream:**
  - Stimulus: assert `rst`=0 for one edge while an sw and an ALU op with rd=7 are in M.
  - Required: no memory change, all outputs 0 the next cycle, normal results after release.
- **Wrap-around and mux:**
  - Stimulus: with `DEPTH`=1024, sw to 0x1010, then lw 0x0010.
  - Required: returns the stored data.
  - Also: ResultSrc=10 with `PCPlus4M`=0x104 gives `ResultW`=0x104.
